// File: rtl/prod_accum.sv
// prod_accum: sums a fixed number of 8-bit unsigned products into a wider
// accumulator. Products arrive on a valid/ready handshake. The finished sum is
// held on a valid/ready output until downstream takes it.
module prod_accum #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [7:0]       prod_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       count,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_reg;
  logic [ACC_W-1:0]   acc_reg;
  logic [4:0]         count_reg;
  logic               out_valid_reg;
  logic               busy_reg;

  logic               xfer;
  logic               last_term;
  logic [ACC_W-1:0]   prod_ext;

  // Input is only refused while a finished result waits to be taken.
  assign in_ready  = (state_reg != DONE);
  assign xfer      = in_valid && in_ready;
  assign last_term = (count_reg == 5'(N_TERMS - 1));
  assign prod_ext  = ACC_W'(prod_in);

  // Accumulator state machine; clr aborts and wins over any handshake in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      count_reg     <= '0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else if (clr) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      count_reg     <= '0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // First product loads rather than adds, so the previous sum never leaks in.
          if (xfer) begin
            acc_reg   <= prod_ext;
            count_reg <= 5'd1;
            state_reg <= ACCUM;
            busy_reg  <= 1'b1;
          end
        end
        ACCUM: begin
          if (xfer) begin
            acc_reg   <= acc_reg + prod_ext;
            count_reg <= count_reg + 5'd1;
            if (last_term) begin
              state_reg     <= DONE;
              out_valid_reg <= 1'b1;
            end
          end
        end
        DONE: begin
          // acc_reg is left alone so the last sum stays visible after acceptance.
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            count_reg     <= '0;
            busy_reg      <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
          count_reg     <= '0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign acc_out   = acc_reg;
  assign count     = count_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_prod_accum.sv
// Testbench for prod_accum: directed scenarios plus randomized traffic.
// Expected sums come from a product-list model and feed a scoreboard queue
// that a separate monitor drains on each output acceptance.
module tb_prod_accum;

  localparam int N = 4;
  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         clr = 1'b0;
  logic [7:0]   prod_in = 8'd0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] acc_out;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [4:0]   count;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int prods_q[$];
  int exp_q[$];
  bit rand_mode = 1'b0;

  prod_accum #(.N_TERMS(N), .ACC_W(W)) dut (
    .clk(clk), .rst(rst), .clr(clr), .prod_in(prod_in), .in_valid(in_valid),
    .in_ready(in_ready), .acc_out(acc_out), .out_valid(out_valid),
    .out_ready(out_ready), .count(count), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a result is the sum of the last N accepted products, modulo 2^W.
  task automatic model_accept(input int p, output bit complete);
    int sum;
    prods_q.push_back(p);
    complete = 1'b0;
    if (prods_q.size() == N) begin
      sum = 0;
      foreach (prods_q[i]) sum += prods_q[i];
      exp_q.push_back(sum % (1 << W));
      prods_q.delete();
      complete = 1'b1;
    end
  endtask

  // Offer one product after 'gap' idle cycles and wait for it to be accepted.
  task automatic send(input logic [7:0] p, input int gap);
    bit complete;
    int w;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      if (prods_q.size() > 0) check("count_hold", int'(count), prods_q.size());
    end
    prod_in  = p;
    in_valid = 1'b1;
    w = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      w++;
      if (w > 200) begin
        checks++; errors++;
        $display("FAIL in_ready_timeout: got 0 expected 1 within 200 cycles");
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_accept(int'(p), complete);
    if (complete) begin
      check("out_valid_on_last", int'(out_valid), 1);
      check("count_done", int'(count), N);
    end else begin
      check("count_step", int'(count), prods_q.size());
      check("out_valid_early", int'(out_valid), 0);
    end
    check("busy_active", int'(busy), 1);
    $display("xfer prod=%0d count=%0d out_valid=%0d", p, count, out_valid);
  endtask

  // Monitor: compare held result against scoreboard head; pop on acceptance.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got acc_out=%0d with no result expected", acc_out);
        end else begin
          check("acc_out", int'(acc_out), exp_q[0]);
          if (out_ready) begin
            $display("result acc_out=%0d expected=%0d", acc_out, exp_q[0]);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // Random output backpressure during the randomized phase.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_mode) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int w;
    // Reset asserted before any clock edge: outputs must clear without one.
    #3 rst = 1'b1;
    #1;
    check("rst_acc", int'(acc_out), 0);
    check("rst_count", int'(count), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_in_ready", int'(in_ready), 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic back-to-back sum.
    out_ready = 1'b1;
    send(8'd180, 0); send(8'd143, 0); send(8'd126, 0); send(8'd77, 0);
    @(posedge clk); #1;
    check("basic_valid_drop", int'(out_valid), 0);
    check("basic_count_zero", int'(count), 0);
    check("basic_acc_retained", int'(acc_out), 526);

    // Input bubbles of 2 cycles.
    send(8'd180, 2); send(8'd143, 2); send(8'd126, 2); send(8'd77, 2);
    @(posedge clk); #1;

    // Output backpressure with a product presented during DONE.
    out_ready = 1'b0;
    send(8'd180, 0); send(8'd143, 0); send(8'd126, 0); send(8'd77, 0);
    prod_in  = 8'd200;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_count", int'(count), N);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_accept_valid", int'(out_valid), 0);
    check("bp_accept_count", int'(count), 0);
    @(posedge clk); #1;
    check("bp_single_accept", int'(out_valid), 0);

    // Maximum value.
    send(8'd225, 0); send(8'd225, 0); send(8'd225, 0); send(8'd225, 0);
    @(posedge clk); #1;
    check("max_acc", int'(acc_out), 900);

    // clr after two transfers, coincident with a third product.
    send(8'd5, 0); send(8'd6, 0);
    prod_in  = 8'd99;
    in_valid = 1'b1;
    clr      = 1'b1;
    @(posedge clk); #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    prods_q.delete();
    check("clr_count", int'(count), 0);
    check("clr_acc", int'(acc_out), 0);
    check("clr_busy", int'(busy), 0);
    check("clr_out_valid", int'(out_valid), 0);
    send(8'd10, 0); send(8'd20, 0); send(8'd30, 0); send(8'd40, 0);
    @(posedge clk); #1;
    check("clr_final_acc", int'(acc_out), 100);

    // Async reset while a result is held.
    out_ready = 1'b0;
    send(8'd50, 0); send(8'd60, 0); send(8'd70, 0); send(8'd80, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_acc", int'(acc_out), 0);
    check("arst_count", int'(count), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_in_ready", int'(in_ready), 1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(8'd1, 0); send(8'd2, 0); send(8'd3, 0); send(8'd4, 0);
    @(posedge clk); #1;
    check("post_rst_acc", int'(acc_out), 10);

    // Randomized traffic with random gaps and backpressure.
    rand_mode = 1'b1;
    for (int t = 0; t < 80; t++)
      send(8'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
    rand_mode = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(posedge clk);
      w++;
    end
    #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prod_accum.md
# prod_accum

Sequential accumulator that sits directly downstream of the combinational 4x4 array multiplier. It consumes the 8-bit product stream under a valid/ready handshake and sums a fixed number of products, N_TERMS, into a wider accumulator. It then presents the sum on a held output handshake; together with the multiplier it forms a dot-product / MAC stage.

## Interface
- N_TERMS, default 4: products summed per result; legal range 2..16.
- ACC_W, default 12: accumulator width; must be >= 8 + ceil(log2(N_TERMS)).
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous abort of the current accumulation.
- prod_in  input  8  unsigned product from the multiplier.
- in_valid  input  1  prod_in is valid this cycle.
- in_ready  output  1  block accepts prod_in this cycle.
- acc_out  output  ACC_W  accumulated sum.
- out_valid  output  1  acc_out holds a completed result.
- out_ready  input  1  downstream accepts the result.
- count  output  5  number of products accepted in the current accumulation.
- busy  output  1  high in ACCUM or DONE.

## Operation
- States:
  - IDLE: count = 0, nothing accepted yet.
  - ACCUM: 1 <= count <= N_TERMS-1.
  - DONE: result held.
- Transfer condition: in_valid && in_ready. in_ready = 1 in IDLE and ACCUM, 0 in DONE (combinational from state).
- IDLE, on transfer:
  - acc <= zero-extended prod_in (load, not add); count <= 1.
  - Next state is ACCUM.
- ACCUM, on transfer:
  - acc <= acc + prod_in, unsigned, modulo 2^ACC_W; count <= count + 1.
  - When the transfer is the N_TERMS-th product: state -> DONE, out_valid <= 1.
- ACCUM with no transfer: all registers hold. Gaps in in_valid are allowed.
- DONE:
  - acc_out, count and out_valid are all held; count reads N_TERMS.
  - On out_valid && out_ready: state -> IDLE, out_valid <= 0, count <= 0.
  - acc_out retains the last sum after the result is accepted.
- clr = 1 at a clock edge:
  - state -> IDLE, count <= 0, acc <= 0, out_valid <= 0.
  - clr overrides any simultaneous input transfer or output acceptance. The product presented in that cycle is dropped.
- prod_in is not range-checked. All 8-bit values are accumulated as given.
- Width rule: with the default parameters the maximum sum is 4*225 = 900, so the result is never truncated. Narrower ACC_W wraps silently.

## Timing
- Reset (rst = 1, asynchronous): state IDLE, acc_out = 0, count = 0, out_valid = 0, busy = 0. in_ready = 1 one propagation delay after rst asserts.
- Release of rst is synchronous to clk. The first transfer may occur on the first rising edge after deassertion.
- Reset asserted mid-accumulation or in DONE discards everything immediately. No partial result is ever presented.
- Latency: out_valid rises on the clock edge of the N_TERMS-th transfer, i.e. it is visible in the cycle after that transfer.
- Minimum result period is N_TERMS + 1 cycles. That is N_TERMS input cycles plus one DONE cycle, with out_ready tied high.
- Input is blocked while in DONE. A new accumulation's first transfer can occur in the cycle after the output is accepted.
- Handshake obligations:
  - out_valid never drops without acceptance, clr or rst.
  - acc_out is stable while out_valid && !out_ready.
- All outputs are registered except in_ready, which is decoded from state.

## Test plan
- Basic sum, back-to-back transfers: feed products 180, 143, 126, 77 (15x12, 11x13, 9x14, 7x11) with out_ready = 1.
  - out_valid is high in cycle 5.
  - acc_out = 526 (0x20E).
  - out_valid is low in cycle 6; count returns to 0.
- Input bubbles: same four products, with in_valid low for 2 cycles between each.
  - Same result, 526.
  - count steps 1, 2, 3, 4 only on transfers.
- Output backpressure: hold out_ready = 0 for 5 cycles after the result.
  - out_valid stays 1, acc_out stays 526, in_ready stays 0.
  - A prod_in presented with in_valid = 1 during this window is ignored.
  - Raising out_ready produces exactly one acceptance.
- Maximum value: four products of 225.
  - acc_out = 900 (0x384).
  - No wrap with ACC_W = 12.
- clr mid-operation: pulse clr after 2 transfers, coincident with a third in_valid; then feed 10, 20, 30, 40.
  - count = 0 after clr; the coincident product is dropped.
  - Final acc_out = 100.
- Async reset: assert rst between clock edges while in DONE.
  - out_valid, acc_out and count go to 0 immediately, without waiting for a clock edge.
  - The next accumulation after release behaves normally.
